uart_tx_arbiter: RTL

Message-granular round-robin arbiter sharing the single `uart_tx` transmitter among up to four byte-stream requesters (e.g. PicoBlaze port writes, hardware CRC/count reporter). It sits between the requesters and `uart_tx`: it owns `uart_tx`'s `data`/`write` inputs and watches its `ready` output. A grant is held until the requester's byte flagged `last` has been handed to the transmitter, so multi-byte messages are never interleaved.

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : message-granular round-robin arbiter in front of uart_tx.
// Optional forced release of a stalled grant: define UART_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_write_o,
  input  logic                 tx_ready_i,
  output logic [1:0]           grant_id_o,
  output logic                 busy_o,
  output logic                 timeout_evt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);

  if ((NUM_REQ < 2) || (NUM_REQ > 4) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("uart_tx_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
  end

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_write_q, tx_write_d;
  logic       last_q, last_d;

  // Requester views widened to four lanes so a 2-bit grant can index them.
  logic [3:0] valid_ext;
  logic [3:0] last_ext;
  logic [7:0] data_ext [4];

  for (genvar g = 0; g < 4; g++) begin : g_ext
    if (g < NUM_REQ) begin : g_used
      assign valid_ext[g] = req_valid_i[g];
      assign last_ext[g]  = req_last_i[g];
      assign data_ext[g]  = req_data_i[8*g +: 8];
    end else begin : g_unused
      assign valid_ext[g] = 1'b0;
      assign last_ext[g]  = 1'b0;
      assign data_ext[g]  = 8'h00;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign req_ready_o[g] = (state_q == ST_LOAD) && tx_ready_i && (grant_q == 2'(g));
  end

  function automatic logic [1:0] wrap_idx(input logic [2:0] v);
    if (v >= 3'(NUM_REQ)) begin
      return 2'(v - 3'(NUM_REQ));
    end
    return v[1:0];
  endfunction

  logic       found;
  logic [1:0] winner;
  logic       handshake;
  logic [1:0] next_ptr;

  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && valid_ext[wrap_idx({1'b0, rr_q} + 3'(k))]) begin
        found  = 1'b1;
        winner = wrap_idx({1'b0, rr_q} + 3'(k));
      end
    end
  end

  assign handshake = (state_q == ST_LOAD) && tx_ready_i && valid_ext[grant_q];
  assign next_ptr  = (grant_q == LAST_ID) ? 2'd0 : grant_q + 2'd1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tevt_q, tevt_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    tx_data_d  = tx_data_q;
    tx_write_d = 1'b0;
    last_d     = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    tevt_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found && tx_ready_i) begin
          grant_d = winner;
          state_d = ST_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          tx_data_d  = data_ext[grant_q];
          tx_write_d = 1'b1;
          last_d     = last_ext[grant_q];
          state_d    = ST_GUARD;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TIMEOUT_VAL) begin
            tevt_d  = 1'b1;
            rr_d    = next_ptr;
            state_d = ST_IDLE;
          end
        end
`endif
      end
      // The transmitter needs a cycle to drop ready after the write pulse.
      ST_GUARD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_ready_i) begin
          if (last_q) begin
            rr_d    = next_ptr;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'd0;
      rr_q       <= 2'd0;
      tx_data_q  <= 8'h00;
      tx_write_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      tx_data_q  <= tx_data_d;
      tx_write_q <= tx_write_d;
      last_q     <= last_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tevt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tevt_q <= tevt_d;
    end
  end

  assign timeout_evt_o = tevt_q;
`else
  assign timeout_evt_o = 1'b0;
`endif

  assign tx_data_o  = tx_data_q;
  assign tx_write_o = tx_write_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire
